// File: rtl/mem_stall_ctrl_pkg.sv
// Shared types and sizing helpers for the load/store stall controller.
package mem_stall_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} stall_state_t;

   // Bits needed to hold the larger of the latency and timeout limits.
   function automatic int unsigned clog2max(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/mem_stall_ctrl_if.sv
// Core-side handshake between the datapath and the data-memory stall controller.
interface mem_stall_ctrl_if #(
   parameter int unsigned PERF_W = 32
);
   logic              mem_req_i;
   logic              mem_we_i;
   logic              mem_ready_i;
   logic              stall_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic              timeout_o;
   logic [PERF_W-1:0] stall_cycles_o;

   modport master (
      output mem_req_i, mem_we_i, mem_ready_i,
      input  stall_o, mem_req_o, mem_we_o, timeout_o, stall_cycles_o
   );

   modport slave (
      input  mem_req_i, mem_we_i, mem_ready_i,
      output stall_o, mem_req_o, mem_we_o, timeout_o, stall_cycles_o
   );
endinterface

// File: rtl/mem_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_o <= '0;
      end else if (inc_i && (count_o != '1)) begin
         count_o <= count_o + 1'b1;
      end
   end

endmodule

// File: rtl/mem_stall_ctrl.sv
// Load/store stall controller: holds the core for a fixed latency or until memory
// ready (with timeout), then frees it for one cycle. Counts stalled cycles.
module mem_stall_ctrl
   import mem_stall_pkg::*;
#(
   parameter int unsigned LATENCY   = 1,
   parameter int unsigned USE_READY = 0,
   parameter int unsigned TIMEOUT   = 255,
   parameter int unsigned PERF_W    = 32
) (
   input logic              clk_i,
   input logic              rst_i,
   mem_stall_ctrl_if.slave  bus
);

   localparam int unsigned      CNT_W    = clog2max(LATENCY, TIMEOUT);
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT);

   stall_state_t     state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             timeout_q, timeout_nxt;
   logic             stall;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         timeout_q <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      timeout_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.mem_req_i) begin
               if ((USE_READY == 0) ? (LATENCY == 1) : bus.mem_ready_i) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = CNT_W'(1);
               end
            end
         end
         ST_WAIT: begin
            // A dropped request (flush) wins over completion and timeout.
            if (!bus.mem_req_i) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else if (USE_READY == 0) begin
               if (cnt == LAT_LAST) state_nxt = ST_DONE;
               else                 cnt_nxt   = cnt + 1'b1;
            end else if (bus.mem_ready_i) begin
               state_nxt = ST_DONE;
            end else if (cnt == TO_LAST) begin
               state_nxt   = ST_DONE;
               timeout_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign stall              = !rst_i && bus.mem_req_i && (state != ST_DONE);
   assign bus.stall_o        = stall;
   assign bus.mem_req_o      = stall;
   assign bus.mem_we_o       = stall && bus.mem_we_i;
   assign bus.timeout_o      = timeout_q;

   sat_counter #(
      .W (PERF_W)
   ) u_perf (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (stall),
      .count_o (bus.stall_cycles_o)
   );

endmodule
